// File: rtl/apb_uart_requester.sv
// APB requester: takes one command at a time over valid/ready, runs a SETUP/ACCESS transfer
// against the UART's APB slave port, and reports data/status on a one-cycle response strobe.
module apb_uart_requester #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    localparam int W      = $clog2(TIMEOUT + 1)
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [W-1:0]      rsp_wait,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      cnt_q, cnt_d;
    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic [W-1:0]      rsp_wait_d;

    // Handshake: a command transfers on the edge where cmd_valid & cmd_ready; cmd_ready is
    // high only in IDLE outside reset, so nothing is held or queued while a transfer runs.
    assign cmd_ready = (state_q == IDLE) & ~PRESET;
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        rsp_wait_d  = rsp_wait;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY wins over the timeout when both land on the same edge.
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_wait_d  = cnt_q;
                    rsp_rdata_d = PWRITE ? '0 : PRDATA;
                    state_d     = IDLE;
                end else if (cnt_q == W'(TIMEOUT - 1)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_wait_d  = W'(TIMEOUT);
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            rsp_wait  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_wait  <= rsp_wait_d;
        end
    end

endmodule

// File: tb/tb_apb_uart_requester.sv
// Directed bench for apb_uart_requester: the bench plays the APB slave by hand,
// and every expected value below is worked out from the transfer timeline.
module tb_apb_uart_requester;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [4:0] rsp_wait;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    apb_uart_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_wait(rsp_wait),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .dbg_state(dbg_state)
    );

    always #5 PCLK = ~PCLK;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic step();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 8'h77;
        PRDATA = 8'h00; PREADY = 1'b0;

        // 1: reset held two cycles with a pending command
        step(); step();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_wait, rsp_rdata}, 0);
        chk("rst_ready", cmd_ready, 0);
        PRESET = 1'b0; cmd_valid = 1'b0;
        #1 chk("rel_ready", cmd_ready, 1);
        step();
        chk("rel_idle_psel", PSEL, 0);

        // 2: zero-wait write 0xD4 -> 0x04
        issue(1'b1, 8'h04, 8'hD4); PREADY = 1'b1;
        step(); cmd_valid = 1'b0;
        chk("wr_setup", {PSEL, PENABLE, PWRITE}, 3'b101);
        chk("wr_setup_addr", PADDR, 8'h04);
        chk("wr_setup_data", PWDATA, 8'hD4);
        chk("wr_setup_ready", cmd_ready, 0);
        step();
        chk("wr_access", {PSEL, PENABLE, rsp_valid}, 3'b110);
        chk("wr_access_addr", PADDR, 8'h04);
        step();
        chk("wr_done_apb", {PSEL, PENABLE}, 2'b00);
        chk("wr_done_rsp", {rsp_valid, rsp_err, rsp_wait, rsp_rdata}, {1'b1, 1'b0, 5'd0, 8'h00});
        chk("wr_done_ready", cmd_ready, 1);
        step();
        chk("wr_strobe_one", rsp_valid, 0);

        // 3: read 0x0C with three wait states returning 0x5A
        PREADY = 1'b0; PRDATA = 8'hFF;
        issue(1'b0, 8'h0C, 8'h99);
        step(); cmd_valid = 1'b0;
        chk("rd_setup", {PSEL, PENABLE, PWRITE}, 3'b100);
        chk("rd_setup_addr", PADDR, 8'h0C);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_wait", {PSEL, PENABLE, rsp_valid}, 3'b110);
        end
        PREADY = 1'b1; PRDATA = 8'h5A;
        step();
        PREADY = 1'b0; PRDATA = 8'hEE;
        chk("rd_done_apb", {PSEL, PENABLE}, 2'b00);
        chk("rd_done_rsp", {rsp_valid, rsp_err, rsp_wait, rsp_rdata}, {1'b1, 1'b0, 5'd3, 8'h5A});
        step();
        chk("rd_hold", {rsp_valid, rsp_wait, rsp_rdata}, {1'b0, 5'd3, 8'h5A});

        // 4: PREADY stuck low -> timeout after 16 ACCESS cycles
        PRDATA = 8'h77;
        issue(1'b0, 8'h08, 8'h00);
        step(); cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_wait", {PSEL, PENABLE, rsp_valid}, 3'b110);
        end
        step();
        chk("to_apb", {PSEL, PENABLE}, 2'b00);
        chk("to_rsp", {rsp_valid, rsp_err, rsp_wait, rsp_rdata}, {1'b1, 1'b1, 5'd16, 8'h00});
        issue(1'b1, 8'h10, 8'h3C); PREADY = 1'b1;
        step(); cmd_valid = 1'b0;
        chk("post_to_setup", {PSEL, PADDR, PWDATA}, {1'b1, 8'h10, 8'h3C});
        step(); step();
        chk("post_to_rsp", {rsp_valid, rsp_err, rsp_wait}, {1'b1, 1'b0, 5'd0});

        // Boundary: PREADY arrives on the edge the counter reaches TIMEOUT-1
        PREADY = 1'b0;
        issue(1'b0, 8'h02, 8'h00);
        step(); cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 15; i++) step();
        chk("bnd_still_busy", {PSEL, rsp_valid}, 2'b10);
        PREADY = 1'b1; PRDATA = 8'hA5;
        step();
        PREADY = 1'b0;
        chk("bnd_rsp", {rsp_valid, rsp_err, rsp_wait, rsp_rdata}, {1'b1, 1'b0, 5'd15, 8'hA5});

        // 5: reset during ACCESS aborts silently
        issue(1'b1, 8'h06, 8'h11);
        step(); cmd_valid = 1'b0;
        step(); step();
        chk("mid_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        #1 chk("mid_rst_ready", cmd_ready, 0);
        step();
        chk("mid_rst_apb", {PSEL, PENABLE, PADDR}, {2'b00, 8'h00});
        chk("mid_rst_state", dbg_state, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_wait}, 0);
        PRESET = 1'b0;
        step();
        chk("mid_rel_rsp", rsp_valid, 0);
        issue(1'b0, 8'h01, 8'h00); PREADY = 1'b1; PRDATA = 8'h99;
        step(); cmd_valid = 1'b0;
        step(); step();
        chk("mid_new_rsp", {rsp_valid, rsp_err, rsp_wait, rsp_rdata}, {1'b1, 1'b0, 5'd0, 8'h99});

        // 6: cmd_valid held high with a moving address
        step();
        PRDATA = 8'h42;
        issue(1'b0, 8'h20, 8'h00);
        step(); cmd_addr = 8'h21;
        chk("hold_setup_addr", {PSEL, PENABLE, PADDR}, {2'b10, 8'h20});
        step(); cmd_addr = 8'h23;
        chk("hold_access_addr", {PSEL, PENABLE, PADDR}, {2'b11, 8'h20});
        step();
        chk("hold_done", {rsp_valid, rsp_rdata, PSEL, cmd_ready}, {1'b1, 8'h42, 1'b0, 1'b1});
        step(); cmd_valid = 1'b0;
        chk("b2b_accept", {PSEL, PENABLE, PADDR}, {2'b10, 8'h23});
        step(); step();
        chk("b2b_rsp", {rsp_valid, rsp_rdata}, {1'b1, 8'h42});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
